adc_result_avg: RTL and testbench
=================================

ADC_RESULT_AVG -- requirements
Module: adc_result_avg

Interface
REQ-001 Parameter WIDTH, default 8, bit width of SAR conversion result.
REQ-002 Parameter ACC_W, default 14, accumulator width (WIDTH+6, covers 64 samples).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_result  input  WIDTH  conversion result from sar_control.
REQ-006 in_valid  input  1  conversion-done flag from sar_control (pulse or level).
REQ-007 enable  input  1  high = accept samples; low = ignore samples, hold state.
REQ-008 clear  input  1  synchronous restart of current block.
REQ-009 avg_sel  input  2  block length select: 0=1, 1=4, 2=16, 3=64 samples.
REQ-010 out_ready  input  1  consumer accepts avg_out when high with out_valid.
REQ-011 avg_out  output  WIDTH  rounded block average.
REQ-012 blk_min  output  WIDTH  minimum sample of completed block.
REQ-013 blk_max  output  WIDTH  maximum sample of completed block.
REQ-014 out_valid  output  1  result registers hold an unconsumed block result.
REQ-015 overrun  output  1  sticky: a block completed while out_valid was still high.

Function
REQ-016 Sample accept = rising edge of in_valid (in_valid=1, registered in_valid_q=0) AND enable=1; level-high in_valid counts once.
REQ-017 FSM states: IDLE (no samples in block), ACCUM (1..N-1 samples taken), DONE (one cycle, result transfer).
REQ-018 IDLE -> ACCUM on first accepted sample; latch avg_sel into k_lat (k = 0,2,4,6); acc=sample, min=max=sample, cnt=1.
REQ-019 IDLE -> DONE directly on accepted sample when avg_sel=0 (N=1).
REQ-020 ACCUM: each accepted sample adds to acc, updates running min/max, increments cnt; cnt reaching N -> DONE.
REQ-021 avg_sel changes mid-block have no effect until next IDLE->ACCUM transition.
REQ-022 DONE: avg_out = (acc + 2^(k-1)) >> k (no rounding term when k=0), result saturated to 2^WIDTH-1; blk_min/blk_max loaded; out_valid set; next state IDLE.
REQ-023 Latency: last sample accepted at edge E -> avg_out/out_valid valid after edge E+1.
REQ-024 A sample accepted during DONE is lost and does not start a new block (sar_control rate makes this unreachable; documented only).
REQ-025 Handshake: out_valid clears on edge where out_valid=1 and out_ready=1; avg_out/blk_min/blk_max stable while out_valid=1 and no new DONE.
REQ-026 DONE with out_valid=1 and out_ready=0: registers overwritten with new result, out_valid stays 1, overrun set.
REQ-027 DONE coinciding with out_ready=1 handshake: new result loaded, out_valid stays 1, overrun not set.
REQ-028 enable=0: partial acc/cnt/min/max held; accumulation resumes on next accepted sample.
REQ-029 clear=1: FSM -> IDLE, acc/cnt zero, out_valid=0, overrun=0; avg_out/blk_min/blk_max retained; clear wins over simultaneous sample accept or DONE.
REQ-030 No accumulator overflow for any legal N: max acc = 64*(2^WIDTH-1) < 2^ACC_W.

Reset
REQ-031 rst_n=0 asynchronously: FSM=IDLE, acc=0, cnt=0, in_valid_q=0, k_lat=0, avg_out=0, blk_min=0, blk_max=0, out_valid=0, overrun=0.
REQ-032 Outputs remain at reset values until first DONE after rst_n deasserts; reset mid-block discards partial block.

Verification
REQ-033 avg_sel=0, in_valid pulse with in_result=0xA5 -> one cycle later avg_out=0xA5, blk_min=blk_max=0xA5, out_valid=1.
REQ-034 avg_sel=1, samples 10,11,11,11 -> avg_out=11 ((43+2)>>2), blk_min=10, blk_max=11; in_valid held high 5 cycles counts as one sample.
REQ-035 avg_sel=3, 64 samples of 0xFF -> avg_out=0xFF, no overflow; switching avg_sel to 0 after sample 3 leaves block length 64.
REQ-036 out_ready=0, two consecutive N=1 blocks (0x20 then 0x40) -> avg_out=0x40, overrun=1; clear -> out_valid=0, overrun=0, avg_out=0x40.
REQ-037 avg_sel=2, 8 samples then enable=0 with 3 in_valid pulses, enable=1 with 8 more -> out_valid only after 16th accepted sample.
REQ-038 rst_n asserted after 2 of 4 samples -> all outputs zero immediately; next 4 samples produce fresh block result.

Source files
------------

// File: rtl/adc_result_avg.sv
`default_nettype none
// ============================================================================
// Module      : adc_result_avg
// Description : Block averager for SAR conversion results (N = 1/4/16/64),
//               with rounded mean, block min/max and a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_result_avg #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_valid,
    input  logic             enable,
    input  logic             clear,
    input  logic [1:0]       avg_sel,
    input  logic             out_ready,
    output logic [WIDTH-1:0] avg_out,
    output logic [WIDTH-1:0] blk_min,
    output logic [WIDTH-1:0] blk_max,
    output logic             out_valid,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             in_valid_q;
    logic [2:0]       k_q, k_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] avg_q, avg_d;
    logic [WIDTH-1:0] bmin_q, bmin_d;
    logic [WIDTH-1:0] bmax_q, bmax_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    logic             w_accept;
    logic [6:0]       w_blk_len;
    logic [6:0]       w_cnt_inc;
    logic [ACC_W:0]   w_round;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W:0]   w_shift;
    logic [WIDTH-1:0] w_avg;

    // A level-high in_valid yields exactly one sample on its rising edge.
    assign w_accept  = in_valid & ~in_valid_q & enable;
    assign w_blk_len = 7'd1 << k_q;
    assign w_cnt_inc = cnt_q + 7'd1;

    assign w_round = (k_q == 3'd0) ? '0 : ((ACC_W+1)'(1) << (k_q - 3'd1));
    assign w_sum   = {1'b0, acc_q} + w_round;
    assign w_shift = w_sum >> k_q;
    assign w_avg   = (|w_shift[ACC_W:WIDTH]) ? '1 : w_shift[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        min_d       = min_q;
        max_d       = max_q;
        avg_d       = avg_q;
        bmin_d      = bmin_q;
        bmax_d      = bmax_q;
        out_valid_d = out_valid_q & ~out_ready;
        overrun_d   = overrun_q;

        if (clear) begin
            // Result registers are deliberately left untouched by clear.
            state_d     = S_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        k_d     = {avg_sel, 1'b0};
                        acc_d   = ACC_W'(in_result);
                        min_d   = in_result;
                        max_d   = in_result;
                        cnt_d   = 7'd1;
                        state_d = (avg_sel == 2'd0) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        acc_d = acc_q + ACC_W'(in_result);
                        if (in_result < min_q) min_d = in_result;
                        if (in_result > max_q) max_d = in_result;
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == w_blk_len) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    avg_d       = w_avg;
                    bmin_d      = min_q;
                    bmax_d      = max_q;
                    out_valid_d = 1'b1;
                    if (out_valid_q && !out_ready) overrun_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_valid_q  <= 1'b0;
            k_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            avg_q       <= '0;
            bmin_q      <= '0;
            bmax_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_valid_q  <= in_valid;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            min_q       <= min_d;
            max_q       <= max_d;
            avg_q       <= avg_d;
            bmin_q      <= bmin_d;
            bmax_q      <= bmax_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign avg_out   = avg_q;
    assign blk_min   = bmin_q;
    assign blk_max   = bmax_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_result_avg.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_result_avg
// Description : Self-checking bench for adc_result_avg against a block model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_result_avg;

    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_result;
    logic       in_valid;
    logic       enable;
    logic       clear;
    logic [1:0] avg_sel;
    logic       out_ready;
    logic [7:0] avg_out;
    logic [7:0] blk_min;
    logic [7:0] blk_max;
    logic       out_valid;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: samples of the open block, and a finished
    // block waiting one edge before it appears on the outputs.
    int q_s[$];
    int blk_n;
    bit pend;
    int p_avg, p_min, p_max;
    int e_avg, e_min, e_max;
    bit e_vld, e_ov;
    bit prev_iv;

    adc_result_avg #(.WIDTH(8), .ACC_W(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_result (in_result),
        .in_valid  (in_valid),
        .enable    (enable),
        .clear     (clear),
        .avg_sel   (avg_sel),
        .out_ready (out_ready),
        .avg_out   (avg_out),
        .blk_min   (blk_min),
        .blk_max   (blk_max),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_s.delete();
        blk_n   = 1;
        pend    = 1'b0;
        p_avg   = 0; p_min = 0; p_max = 0;
        e_avg   = 0; e_min = 0; e_max = 0;
        e_vld   = 1'b0;
        e_ov    = 1'b0;
        prev_iv = 1'b0;
    endtask

    // Evaluated with the inputs present just before a rising edge.
    task automatic model_step();
        bit acc, was;
        int sum, mn, mx;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc     = in_valid && !prev_iv && enable;
        prev_iv = in_valid;
        if (clear) begin
            q_s.delete();
            pend  = 1'b0;
            e_vld = 1'b0;
            e_ov  = 1'b0;
            return;
        end
        was = pend;
        if (pend) begin
            e_avg = p_avg; e_min = p_min; e_max = p_max;
            if (e_vld && !out_ready) e_ov = 1'b1;
            e_vld = 1'b1;
            pend  = 1'b0;
        end else if (e_vld && out_ready) begin
            e_vld = 1'b0;
        end
        if (acc && !was) begin
            if (q_s.size() == 0) blk_n = 1 << (2 * int'(avg_sel));
            q_s.push_back(int'(in_result));
            if (q_s.size() == blk_n) begin
                sum = 0; mn = q_s[0]; mx = q_s[0];
                foreach (q_s[i]) begin
                    sum += q_s[i];
                    if (q_s[i] < mn) mn = q_s[i];
                    if (q_s[i] > mx) mx = q_s[i];
                end
                p_avg = (sum + blk_n / 2) / blk_n;
                if (p_avg > MAXV) p_avg = MAXV;
                p_min = mn;
                p_max = mx;
                pend  = 1'b1;
                q_s.delete();
            end
        end
    endtask

    task automatic compare_all();
        chk("avg_out",   int'(avg_out),   e_avg);
        chk("blk_min",   int'(blk_min),   e_min);
        chk("blk_max",   int'(blk_max),   e_max);
        chk("out_valid", int'(out_valid), int'(e_vld));
        chk("overrun",   int'(overrun),   int'(e_ov));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic pulse(input logic [7:0] s);
        in_result = s;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_result = '0;
        in_valid  = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        avg_sel   = 2'd0;
        out_ready = 1'b0;
        model_reset();
        #12;
        compare_all();
        rst_n = 1'b1;
        tick();

        // Single-sample block
        avg_sel = 2'd0;
        pulse(8'hA5);
        chk("n1_avg", int'(avg_out), 'hA5);
        chk("n1_vld", int'(out_valid), 1);
        consume();

        // Four samples with a long in_valid level counted once
        avg_sel   = 2'd1;
        in_result = 8'd10;
        in_valid  = 1'b1;
        repeat (5) tick();
        in_valid  = 1'b0;
        tick();
        pulse(8'd11); pulse(8'd11); pulse(8'd11);
        chk("n4_avg", int'(avg_out), 11);
        chk("n4_min", int'(blk_min), 10);
        chk("n4_max", int'(blk_max), 11);
        consume();

        // 64 full-scale samples; avg_sel change mid-block ignored
        avg_sel = 2'd3;
        for (int i = 0; i < 64; i++) begin
            if (i == 3) avg_sel = 2'd0;
            pulse(8'hFF);
        end
        chk("n64_avg", int'(avg_out), 'hFF);
        chk("n64_vld", int'(out_valid), 1);
        consume();

        // Overrun then clear
        avg_sel = 2'd0;
        pulse(8'h20);
        pulse(8'h40);
        chk("ovr_avg", int'(avg_out), 'h40);
        chk("ovr_flag", int'(overrun), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_vld", int'(out_valid), 0);
        chk("clr_ovr", int'(overrun), 0);
        chk("clr_avg", int'(avg_out), 'h40);

        // Enable gating of a 16-sample block
        avg_sel = 2'd2;
        for (int i = 0; i < 8; i++) pulse(8'(i * 3));
        enable = 1'b0;
        for (int i = 0; i < 3; i++) pulse(8'hF0);
        enable = 1'b1;
        for (int i = 0; i < 7; i++) pulse(8'(100 + i));
        chk("en_vld15", int'(out_valid), 0);
        pulse(8'd200);
        chk("en_vld16", int'(out_valid), 1);
        chk("en_max", int'(blk_max), 200);
        chk("en_min", int'(blk_min), 0);

        // Asynchronous reset in the middle of a block
        avg_sel = 2'd1;
        pulse(8'd50); pulse(8'd60);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_avg", int'(avg_out), 0);
        tick();
        rst_n = 1'b1;
        pulse(8'd1); pulse(8'd2); pulse(8'd3); pulse(8'd5);
        chk("rst_fresh", int'(avg_out), 3);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0:       in_result = 8'h00;
                1:       in_result = 8'hFF;
                default: in_result = 8'($urandom);
            endcase
            enable    = ($urandom_range(0, 9) != 0);
            clear     = ($urandom_range(0, 149) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) avg_sel = 2'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
